// File: rtl/adxl_spi_ctrl.sv
// ---------------------------------------------------------------------------
// adxl_spi_ctrl
//
// Free-running SPI master for the ADXL362 accelerometer. After reset it
// issues three configuration writes (soft reset, filter control, power
// control). It then polls X, Y, Z, T-low and T-high forever. Each poll
// result is presented on c_ADXL_OUT together with a one-cycle
// ADXL_OUT_ready strobe.
//
// SPI mode 0 (CPOL=0, CPHA=0), MSB first. Every frame is 24 bits long:
// {cmd, addr, data}. For reads the last byte clocked in on miso is the
// register value.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk cycles (2..255)
//   CS_GAP   clk cycles cs_n stays high between frames (2..255)
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   en                   run enable; sampled in IDLE and at the end of GAP
//   miso                 serial data from the sensor
//   sclk, mosi, cs_n     SPI master outputs (registered)
//   c_ADXL_OUT           data byte of the most recent read frame
//   ADXL_OUT_ready       one-cycle strobe; c_ADXL_OUT/out_select valid
//   out_select           command index of the current/most recent frame
//   repeat_count_signal  one-cycle strobe after the T-high (index 7) result
//   init_done            sticky flag; the three configuration writes are done
// ---------------------------------------------------------------------------
module adxl_spi_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [7:0] c_ADXL_OUT,
    output logic       ADXL_OUT_ready,
    output logic [2:0] out_select,
    output logic       repeat_count_signal,
    output logic       init_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state;
    logic [23:0] shreg;      // outgoing frame; bit 23 is the next bit on mosi
    logic [7:0]  rx;         // last eight miso samples
    logic [7:0]  div_cnt;    // clk cycles spent in the current sclk half
    logic [4:0]  bit_cnt;    // frame bit being transferred
    logic [7:0]  gap_cnt;    // clk cycles spent in GAP
    logic [2:0]  nxt_idx;    // command index for the next LOAD
    logic [23:0] load_frame;

    // Fixed command table: {cmd, addr, data}
    function automatic logic [23:0] frame_of(input logic [2:0] idx);
        case (idx)
            3'd0:    frame_of = 24'h0A1F52;  // write SOFT_RESET
            3'd1:    frame_of = 24'h0A2C13;  // write FILTER_CTL
            3'd2:    frame_of = 24'h0A2D02;  // write POWER_CTL, measure
            3'd3:    frame_of = 24'h0B0800;  // read XDATA
            3'd4:    frame_of = 24'h0B0900;  // read YDATA
            3'd5:    frame_of = 24'h0B0A00;  // read ZDATA
            3'd6:    frame_of = 24'h0B1400;  // read TEMP_L
            default: frame_of = 24'h0B1500;  // read TEMP_H
        endcase
    endfunction

    // Configuration writes run once; reads cycle 3..7 indefinitely
    function automatic logic [2:0] next_index(input logic [2:0] idx);
        next_index = (idx == 3'd7) ? 3'd3 : idx + 3'd1;
    endfunction

    assign load_frame = frame_of(nxt_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            shreg               <= '0;
            rx                  <= '0;
            div_cnt             <= '0;
            bit_cnt             <= '0;
            gap_cnt             <= '0;
            nxt_idx             <= '0;
            sclk                <= 1'b0;
            mosi                <= 1'b0;
            cs_n                <= 1'b1;
            c_ADXL_OUT          <= '0;
            ADXL_OUT_ready      <= 1'b0;
            out_select          <= '0;
            repeat_count_signal <= 1'b0;
            init_done           <= 1'b0;
        end else begin
            ADXL_OUT_ready      <= 1'b0;
            repeat_count_signal <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    shreg      <= load_frame;
                    mosi       <= load_frame[23];
                    out_select <= nxt_idx;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    sclk       <= 1'b0;
                    cs_n       <= 1'b0;
                    state      <= SHIFT;
                end

                SHIFT: begin
                    // mosi is updated one cycle into the low half, so it
                    // never moves on a cycle where sclk is or was just high.
                    if (!sclk && div_cnt == 8'd0) begin
                        mosi <= shreg[23];
                    end

                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            // Rising sclk: capture miso on this same edge
                            sclk <= 1'b1;
                            rx   <= {rx[6:0], miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            // Frame done: drop sclk and release cs_n together
                            sclk    <= 1'b0;
                            cs_n    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= GAP;
                            if (out_select >= 3'd3) begin
                                c_ADXL_OUT     <= rx;
                                ADXL_OUT_ready <= 1'b1;
                            end
                            if (out_select == 3'd2) begin
                                init_done <= 1'b1;
                            end
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[22:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    // Bundle marker lands one cycle after the index-7 ready
                    if (gap_cnt == 8'd0 && out_select == 3'd7) begin
                        repeat_count_signal <= 1'b1;
                    end

                    if (gap_cnt == GAP_LAST) begin
                        nxt_idx <= next_index(out_select);
                        state   <= en ? LOAD : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adxl_spi_ctrl
//
// Two instances: defaults (CLK_DIV=4, CS_GAP=8) and the fast corner
// (CLK_DIV=2, CS_GAP=2). Each instance has an ADXL362-like slave model and
// a frame monitor that logs every completed transaction. The logs are
// compared against a table of expected frames and results. Hand-written
// sequences then cover the en-drop and mid-frame reset cases.
// ---------------------------------------------------------------------------
module tb_adxl_spi_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en;
    int         cyc = 0;

    int total = 0;
    int bad   = 0;

    logic [7:0] resp_mem [256];

    typedef struct {
        logic [7:0]  resp;   // slave reply for this frame's address
        logic [2:0]  sel;
        logic [23:0] frame;
        logic        rd;
        logic [7:0]  data;
        logic        rep;
        logic        init;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int CD = (g == 0) ? 4 : 2;
        localparam int CG = (g == 0) ? 8 : 2;

        logic       sclk, mosi, cs_n, rdy, rep, init;
        logic       miso = 1'b0;
        logic [7:0] c_out;
        logic [2:0] sel;

        adxl_spi_ctrl #(.CLK_DIV(CD), .CS_GAP(CG)) dut (
            .clk                (clk),
            .reset              (reset),
            .en                 (en[g]),
            .miso               (miso),
            .sclk               (sclk),
            .mosi               (mosi),
            .cs_n               (cs_n),
            .c_ADXL_OUT         (c_out),
            .ADXL_OUT_ready     (rdy),
            .out_select         (sel),
            .repeat_count_signal(rep),
            .init_done          (init)
        );

        int          ntx = 0, nrdy = 0, nrep = 0;
        int          viol_mosi = 0, viol_coinc = 0, viol_rep = 0;
        logic [23:0] t_frame [256];
        int          t_lo [256], t_rise [256], t_start [256];
        logic        t_rdy [256], t_rep [256], t_init [256];
        logic [7:0]  t_data [256];
        logic [2:0]  t_sel [256];

        logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
        logic        prev_rdy = 1'b0, pend_rep = 1'b0;
        logic [2:0]  prev_sel = '0;
        logic [23:0] cur = '0;
        logic [7:0]  sh = '0, addr = '0, rb;
        int          lo = 0, rises = 0, falls = 0, start = 0;

        always begin
            @(negedge clk);
            if (reset) begin
                prev_cs   = 1'b1;
                prev_sclk = 1'b0;
                prev_mosi = 1'b0;
                prev_rdy  = 1'b0;
                pend_rep  = 1'b0;
                miso      = 1'b0;
            end else begin
                if (pend_rep) begin
                    if (ntx > 0) t_rep[ntx-1] = rep;
                    pend_rep = 1'b0;
                end
                if (!cs_n && prev_cs) begin
                    cur = '0; lo = 0; rises = 0; falls = 0; start = cyc;
                end
                if (!cs_n) begin
                    lo++;
                    if (sclk && !prev_sclk) begin
                        rises++;
                        cur = {cur[22:0], mosi};
                        sh  = {sh[6:0], mosi};
                        if (rises == 16) addr = sh;
                    end
                    if (!sclk && prev_sclk) falls++;
                    if (!prev_cs && (mosi != prev_mosi) && (sclk || prev_sclk)) viol_mosi++;
                end
                if (cs_n && !prev_cs && ntx < 256) begin
                    t_frame[ntx] = cur;
                    t_lo[ntx]    = lo;
                    t_rise[ntx]  = rises;
                    t_start[ntx] = start;
                    t_rdy[ntx]   = rdy;
                    t_data[ntx]  = c_out;
                    t_sel[ntx]   = sel;
                    t_init[ntx]  = init;
                    t_rep[ntx]   = 1'b0;
                    ntx++;
                    pend_rep = 1'b1;
                end
                if (rdy) nrdy++;
                if (rep) begin
                    nrep++;
                    if (!(prev_rdy && prev_sel == 3'd7)) viol_rep++;
                end
                if (rdy && rep) viol_coinc++;
                // Slave shifts out on falling sclk; reply occupies bits 16..23
                rb = resp_mem[addr];
                miso = (!cs_n && falls >= 16 && falls < 24) ? rb[3'(23 - falls)] : 1'b0;
                prev_cs   = cs_n;
                prev_sclk = sclk;
                prev_mosi = mosi;
                prev_rdy  = rdy;
                prev_sel  = sel;
            end
        end
    end

    function automatic int ntx_of(input int g);
        return (g == 0) ? mon[0].ntx : mon[1].ntx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ntx(input int g, input int n, input int max_cyc);
        int c = 0;
        while (ntx_of(g) < n && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        chk($sformatf("i%0d_wait_txn_%0d", g, n), 32'(ntx_of(g) >= n), 32'd1);
    endtask

    task automatic check_rec(input int g, input int k, input int lo_exp, input int per_exp,
                             input logic [23:0] fr, input int lo, input int ri,
                             input logic rd, input logic [7:0] da, input logic [2:0] se,
                             input logic rp, input logic in, input int dst);
        chk($sformatf("i%0d_k%0d_frame", g, k), 32'(fr), 32'(tbl[k].frame));
        chk($sformatf("i%0d_k%0d_cs_low", g, k), 32'(lo), 32'(lo_exp));
        chk($sformatf("i%0d_k%0d_sclk_rises", g, k), 32'(ri), 32'd24);
        chk($sformatf("i%0d_k%0d_ready", g, k), 32'(rd), 32'(tbl[k].rd));
        chk($sformatf("i%0d_k%0d_data", g, k), 32'(da), 32'(tbl[k].data));
        chk($sformatf("i%0d_k%0d_sel", g, k), 32'(se), 32'(tbl[k].sel));
        chk($sformatf("i%0d_k%0d_repeat", g, k), 32'(rp), 32'(tbl[k].rep));
        chk($sformatf("i%0d_k%0d_init", g, k), 32'(in), 32'(tbl[k].init));
        if (k > 0) chk($sformatf("i%0d_k%0d_period", g, k), 32'(dst), 32'(per_exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs_n"},   32'(mon[0].cs_n),  32'd1);
        chk({tag, "_sclk"},   32'(mon[0].sclk),  32'd0);
        chk({tag, "_mosi"},   32'(mon[0].mosi),  32'd0);
        chk({tag, "_data"},   32'(mon[0].c_out), 32'd0);
        chk({tag, "_ready"},  32'(mon[0].rdy),   32'd0);
        chk({tag, "_repeat"}, 32'(mon[0].rep),   32'd0);
        chk({tag, "_sel"},    32'(mon[0].sel),   32'd0);
        chk({tag, "_init"},   32'(mon[0].init),  32'd0);
    endtask

    initial begin
        reset = 1'b0;
        en    = 2'b00;

        //          resp    sel   frame        rd    data   rep   init
        tbl[0] = '{8'hEE, 3'd0, 24'h0A1F52, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'hEE, 3'd1, 24'h0A2C13, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'hEE, 3'd2, 24'h0A2D02, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hA5, 3'd3, 24'h0B0800, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 3'd4, 24'h0B0900, 1'b1, 8'h3C, 1'b0, 1'b1};
        tbl[5] = '{8'h81, 3'd5, 24'h0B0A00, 1'b1, 8'h81, 1'b0, 1'b1};
        tbl[6] = '{8'h5A, 3'd6, 24'h0B1400, 1'b1, 8'h5A, 1'b0, 1'b1};
        tbl[7] = '{8'h0F, 3'd7, 24'h0B1500, 1'b1, 8'h0F, 1'b1, 1'b1};
        for (int k = 8; k < 13; k++) tbl[k] = tbl[k-5];

        for (int a = 0; a < 256; a++) resp_mem[a] = 8'hEE;
        for (int k = 0; k < 8; k++) resp_mem[tbl[k].frame[15:8]] = tbl[k].resp;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        chk("rst_i1_cs_n", 32'(mon[1].cs_n), 32'd1);

        // en low after release: block must stay idle
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_cs_n", 32'(mon[0].cs_n), 32'd1);
        chk("idle_ntx", 32'(mon[0].ntx), 32'd0);

        // Three init writes plus two full read bundles
        en = 2'b11;
        wait_ntx(0, 13, 3000);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 13; k++)
            check_rec(0, k, 192, 201, mon[0].t_frame[k], mon[0].t_lo[k], mon[0].t_rise[k],
                      mon[0].t_rdy[k], mon[0].t_data[k], mon[0].t_sel[k], mon[0].t_rep[k],
                      mon[0].t_init[k], (k > 0) ? mon[0].t_start[k] - mon[0].t_start[k-1] : 0);
        chk("i1_have_13", 32'(mon[1].ntx >= 14), 32'd1);
        for (int k = 0; k < 13; k++)
            check_rec(1, k, 96, 99, mon[1].t_frame[k], mon[1].t_lo[k], mon[1].t_rise[k],
                      mon[1].t_rdy[k], mon[1].t_data[k], mon[1].t_sel[k], mon[1].t_rep[k],
                      mon[1].t_init[k], (k > 0) ? mon[1].t_start[k] - mon[1].t_start[k-1] : 0);
        chk("i0_ready_count", 32'(mon[0].nrdy), 32'd10);
        chk("i0_repeat_count", 32'(mon[0].nrep), 32'd2);

        // Drop en in the middle of the index-5 frame (transaction 15)
        begin
            int c = 0;
            while (!(mon[0].ntx == 15 && mon[0].cs_n == 1'b0) && c < 1000) begin
                @(posedge clk);
                c++;
            end
            chk("wait_idx5_shift", 32'(mon[0].ntx == 15 && mon[0].cs_n == 1'b0), 32'd1);
        end
        repeat (100) @(negedge clk);
        en[0] = 1'b0;
        wait_ntx(0, 16, 400);
        chk("endrop_frame", 32'(mon[0].t_frame[15]), 32'h0B0A00);
        chk("endrop_sel", 32'(mon[0].t_sel[15]), 32'd5);
        chk("endrop_ready", 32'(mon[0].t_rdy[15]), 32'd1);
        chk("endrop_data", 32'(mon[0].t_data[15]), 32'h81);
        chk("endrop_rise", 32'(mon[0].t_rise[15]), 32'd24);
        repeat (400) @(negedge clk);
        chk("idle_after_drop_ntx", 32'(mon[0].ntx), 32'd16);
        chk("idle_after_drop_cs_n", 32'(mon[0].cs_n), 32'd1);
        chk("idle_after_drop_sel", 32'(mon[0].sel), 32'd5);
        en[0] = 1'b1;
        wait_ntx(0, 17, 400);
        chk("resume_frame", 32'(mon[0].t_frame[16]), 32'h0B1400);
        chk("resume_sel", 32'(mon[0].t_sel[16]), 32'd6);
        chk("resume_data", 32'(mon[0].t_data[16]), 32'h5A);

        // Reset in the middle of the index-4 frame (transaction 19)
        begin
            int c = 0;
            while (!(mon[0].ntx == 19 && mon[0].cs_n == 1'b0) && c < 1000) begin
                @(posedge clk);
                c++;
            end
            chk("wait_idx4_shift", 32'(mon[0].ntx == 19 && mon[0].cs_n == 1'b0), 32'd1);
        end
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_hold_cs_n", 32'(mon[0].cs_n), 32'd1);
        reset = 1'b0;
        wait_ntx(0, 20, 400);
        chk("after_rst_frame", 32'(mon[0].t_frame[19]), 32'h0A1F52);
        chk("after_rst_sel", 32'(mon[0].t_sel[19]), 32'd0);
        chk("after_rst_ready", 32'(mon[0].t_rdy[19]), 32'd0);
        chk("after_rst_cs_low", 32'(mon[0].t_lo[19]), 32'd192);
        chk("after_rst_init", 32'(mon[0].t_init[19]), 32'd0);

        for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d_mosi_stable", g),
                32'((g == 0) ? mon[0].viol_mosi : mon[1].viol_mosi), 32'd0);
            chk($sformatf("i%0d_ready_repeat_overlap", g),
                32'((g == 0) ? mon[0].viol_coinc : mon[1].viol_coinc), 32'd0);
            chk($sformatf("i%0d_repeat_position", g),
                32'((g == 0) ? mon[0].viol_rep : mon[1].viol_rep), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adxl_spi_ctrl.md
ADXL_SPI_CTRL -- requirements
Module: adxl_spi_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range is 2 to 255.
REQ-002 Parameter CS_GAP, default 8: number of clk cycles cs_n is held high between transactions; legal range is 2 to 255.
REQ-003 clk  input  1  system clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; the block idles while en is low.
REQ-006 miso  input  1  SPI data from the ADXL362.
REQ-007 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 mosi  output  1  SPI data to the ADXL362, MSB first.
REQ-009 cs_n  output  1  SPI chip select, active-low.
REQ-010 c_ADXL_OUT  output  8  data byte captured during the last read transaction.
REQ-011 ADXL_OUT_ready  output  1  one-cycle pulse; c_ADXL_OUT and out_select are valid in this cycle.
REQ-012 out_select  output  3  command index of the current or most recent transaction.
REQ-013 repeat_count_signal  output  1  one-cycle pulse marking the end of each read bundle.
REQ-014 init_done  output  1  set once the three init writes are complete; sticky until reset.

Function
REQ-015 The block SHALL use a fixed command table indexed by out_select; every entry is a 24-bit frame {cmd, addr, data}:
- 0: write 0x0A, 0x1F, 0x52 (soft reset)
- 1: write 0x0A, 0x2C, 0x13
- 2: write 0x0A, 0x2D, 0x02
- 3: read 0x0B, 0x08, 0x00 (X)
- 4: read 0x0B, 0x09, 0x00 (Y)
- 5: read 0x0B, 0x0A, 0x00 (Z)
- 6: read 0x0B, 0x14, 0x00 (T low)
- 7: read 0x0B, 0x15, 0x00 (T high)
REQ-016 The state machine SHALL have the states IDLE, LOAD, SHIFT and GAP.
REQ-017 IDLE: when en=1, the block SHALL go to LOAD.
REQ-018 LOAD: takes one cycle; the block SHALL load the frame for the current index into a 24-bit shift register and go to SHIFT.
REQ-019 SHIFT: cs_n=0 for exactly 48*CLK_DIV cycles, 24 bits in total.
REQ-020 Each bit in SHIFT SHALL consist of CLK_DIV cycles with sclk=0 followed by CLK_DIV cycles with sclk=1.
REQ-021 mosi SHALL change only while sclk is low, and SHALL be stable before the rising edge of sclk.
REQ-022 miso SHALL be sampled on the clk cycle in which sclk goes 0->1.
REQ-023 The last 8 sampled miso bits SHALL form the data byte, MSB first.
REQ-024 At the end of SHIFT the block SHALL drive sclk=0 and cs_n=1 in the same cycle, then enter GAP.
REQ-025 GAP SHALL last CS_GAP cycles with cs_n=1.
REQ-026 At the end of GAP the block SHALL advance the index and go to LOAD if en=1, or to IDLE if en=0.
REQ-027 Index sequence: 0->1->2->3->4->5->6->7->3, repeating.
REQ-028 init_done SHALL be set in the first GAP cycle after index 2.
REQ-029 Indices 0 to 2 SHALL never reissue until reset.
REQ-030 Read transactions (indices 3 to 7): c_ADXL_OUT SHALL update and ADXL_OUT_ready SHALL pulse on the first GAP cycle.
REQ-031 Write transactions (indices 0 to 2) SHALL produce no ADXL_OUT_ready pulse and SHALL leave c_ADXL_OUT unchanged.
REQ-032 repeat_count_signal SHALL pulse for one cycle, one cycle after the ADXL_OUT_ready pulse of index 7.
REQ-033 repeat_count_signal SHALL never coincide with ADXL_OUT_ready.
REQ-034 out_select SHALL change only in LOAD and SHALL hold its value through GAP.
REQ-035 Deasserting en mid-transaction SHALL NOT abort it: the frame completes and the GAP pulses are still issued.
REQ-036 Transaction period SHALL be 1 (LOAD) + 48*CLK_DIV + CS_GAP cycles, which is 201 with the defaults.
REQ-037 A read bundle (indices 3 to 7) SHALL take 5 times the transaction period.

Reset
REQ-038 While reset=1, the outputs SHALL be: cs_n=1, sclk=0, mosi=0, c_ADXL_OUT=0, ADXL_OUT_ready=0, repeat_count_signal=0, out_select=0, init_done=0; state SHALL be IDLE.
REQ-039 Reset asserted mid-transaction SHALL raise cs_n immediately (asynchronously).
REQ-040 After reset release the block SHALL restart at index 0 and perform the init writes again.

Verification
REQ-041 Reset release, en=1 -> the first frame on mosi is 0x0A1F52; cs_n low for 192 cycles; 24 sclk rising edges; no ready pulse.
REQ-042 An SPI slave model returns 0xA5 for address 0x08 -> ADXL_OUT_ready pulses with c_ADXL_OUT=0xA5 and out_select=3.
REQ-043 Run 2 full read bundles -> out_select sequence is 3,4,5,6,7,3,...; exactly one repeat_count_signal pulse per bundle, 1 cycle after the index-7 ready pulse.
REQ-044 Drop en in the middle of the index-5 SHIFT -> the frame completes; ready pulses with out_select=5; the block goes to IDLE with cs_n=1. Raising en again resumes at index 6.
REQ-045 Assert reset in the middle of the index-4 SHIFT -> cs_n=1 and all outputs are zero at once; after release the next frame is 0x0A1F52.
REQ-046 CLK_DIV=2, CS_GAP=2 -> cs_n low for 96 cycles; transaction period 99 cycles; miso sampling remains correct.
